fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports in this order: Clk input 1 (rising-edge clock); Rst_n input 1 (asynchronous active-low reset).
REQ-002 Port list SHALL be:
- start  input  1  run request (level)
- pc_jmp_en  input  1  jump request from the decoder
- LutPointer  input  4  jump-target LUT index from the decoder
- imem_data  input  9  instruction memory read data; combinational, for imem_addr
- imem_addr  output  10  equals the current PC
- instr  output  9  instruction to the decoder
- instr_valid  output  1  instr is a live instruction
- done  output  1  program-complete acknowledge
- cycle_count  output  16  count of RUN cycles in the current or last program
REQ-003 Parameter SHALL be PC_W, default 10, meaning PC and imem address width.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-005 In IDLE, start=1 SHALL set PC to 0, clear cycle_count and enter RUN on the next edge.
REQ-006 In RUN, instr SHALL equal imem_data combinationally and instr_valid SHALL be 1.
- Exception: when imem_data is HALT, instr SHALL be 9'h000 and instr_valid SHALL be 0.
REQ-007 HALT SHALL be any word with imem_data[8:3]==6'b111111.
REQ-008 Outside RUN, instr SHALL be 9'h000 and instr_valid SHALL be 0; 9'h000 is a side-effect-free compare.
REQ-009 In RUN, on each edge with a non-HALT instruction, the PC SHALL update as follows:
- pc_jmp_en=1: PC <= lut[LutPointer]
- otherwise: PC <= PC+1
REQ-010 PC+1 SHALL wrap from 2^PC_W-1 to 0 with no flag.
REQ-011 A HALT fetch SHALL hold the PC, enter DONE and take priority over a simultaneous pc_jmp_en.
REQ-012 pc_jmp_en and LutPointer SHALL be ignored in IDLE and DONE.
REQ-013 done SHALL be 1 only in DONE.
REQ-014 The FSM SHALL leave DONE for IDLE on the first edge with start=0; while start stays 1 it SHALL remain in DONE.
REQ-015 start SHALL be ignored in RUN; programs are not restartable mid-run.
REQ-016 cycle_count SHALL increment on each RUN-state edge, including the HALT edge, saturate at 16'hFFFF, and hold its value in DONE and IDLE until the next start.
REQ-017 Latency from start sampled high to the first instr_valid SHALL be one cycle.
REQ-018 The LUT SHALL hold 16 entries of PC_W bits, read combinationally.

Reset
REQ-019 Rst_n=0 SHALL immediately force the following, regardless of clock:
- state IDLE, PC 0, cycle_count 0
- done 0, instr_valid 0, instr 9'h000
REQ-020 Reset asserted mid-RUN SHALL abort the program with no further PC update.
REQ-021 LUT contents SHALL be restored to the package defaults on reset.

Configuration
REQ-022 Macro FETCH_LUT_WR_EN defined SHALL add these ports:
- lut_wr_en input 1
- lut_wr_addr input 4
- lut_wr_data input PC_W
REQ-023 With FETCH_LUT_WR_EN defined, a LUT write SHALL take effect on the edge only in IDLE; writes in RUN or DONE SHALL be dropped.
REQ-024 With FETCH_LUT_WR_EN undefined, the ports SHALL be absent and the LUT SHALL be constant package defaults.

Structure
REQ-025 Package fetch_pkg SHALL hold the following:
- the state enum
- HALT_OPCODE (6'b111111)
- NOP_INSTR (9'h000)
- LUT_DEFAULT array (16 x 10)
- CYCLE_W=16
REQ-026 The LUT SHALL be one sub-module, jump_lut, containing storage, reset-to-default and the optional write port.

Verification
REQ-027 Straight line: imem words 0..4 non-jump, word 5 HALT, start=1 ->
- imem_addr goes 0,1,2,3,4,5 on consecutive cycles
- done=1 after the HALT edge
- cycle_count=6
REQ-028 Jump: LUT[3]=10'd40, pc_jmp_en=1 with LutPointer=3 at PC 2 -> next imem_addr=40, then 41.
REQ-029 HALT with pc_jmp_en=1 -> PC holds, DONE entered, instr=9'h000 that cycle.
REQ-030 Handshake: start held 1 in DONE -> done stays 1; start=0 -> IDLE next edge; start=1 again -> PC=0 and cycle_count restarts.
REQ-031 Wrap: jump target 10'h3FF with non-jump instruction -> next imem_addr=0.
REQ-032 Reset pulse mid-RUN at PC 7 -> same-cycle IDLE, PC 0, done 0. With FETCH_LUT_WR_EN: an IDLE write of LUT[1]=99 is honoured; a RUN write is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch unit: FSM states, HALT/NOP encodings and
// the jump-target LUT reset image (used by jump_lut, writable when FETCH_LUT_WR_EN is defined).
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fetch_state_e;

   localparam logic [5:0] HALT_OPCODE = 6'b111111;
   localparam logic [8:0] NOP_INSTR   = 9'h000;
   localparam int         CYCLE_W     = 16;
   localparam int         LUT_DEPTH   = 16;

   localparam logic [9:0] LUT_DEFAULT [LUT_DEPTH] = '{
      10'd0,   10'd16,  10'd32,  10'd40,
      10'd64,  10'd80,  10'd96,  10'd112,
      10'd128, 10'd144, 10'd160, 10'd176,
      10'd192, 10'd208, 10'd224, 10'h3FF
   };

   function automatic logic is_halt(input logic [8:0] word);
      return word[8:3] == HALT_OPCODE;
   endfunction

endpackage

// File: rtl/jump_lut.sv
// 16-entry jump-target table, read combinationally. With FETCH_LUT_WR_EN defined the
// entries are registers reset to LUT_DEFAULT and writable; otherwise they are constants.
module jump_lut
   import fetch_pkg::*;
#(
   parameter int PC_W = 10
) (
`ifdef FETCH_LUT_WR_EN
   input  logic            Clk,
   input  logic            Rst_n,
   input  logic            wr_en_i,
   input  logic [3:0]      wr_addr_i,
   input  logic [PC_W-1:0] wr_data_i,
`endif
   input  logic [3:0]      rd_addr_i,
   output logic [PC_W-1:0] rd_data_o
);

`ifdef FETCH_LUT_WR_EN
   logic [PC_W-1:0] lut_q [LUT_DEPTH];

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < LUT_DEPTH; i++) begin
            lut_q[i] <= PC_W'(LUT_DEFAULT[i]);
         end
      end else if (wr_en_i) begin
         lut_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = lut_q[rd_addr_i];
`else
   assign rd_data_o = PC_W'(LUT_DEFAULT[rd_addr_i]);
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: IDLE/RUN/DONE program control, PC with LUT jumps and HALT
// detection, saturating RUN-cycle counter. FETCH_LUT_WR_EN adds an IDLE-only LUT write port.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int PC_W = 10
) (
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic               start,
   input  logic               pc_jmp_en,
   input  logic [3:0]         LutPointer,
   input  logic [8:0]         imem_data,
`ifdef FETCH_LUT_WR_EN
   input  logic               lut_wr_en,
   input  logic [3:0]         lut_wr_addr,
   input  logic [PC_W-1:0]    lut_wr_data,
`endif
   output logic [PC_W-1:0]    imem_addr,
   output logic [8:0]         instr,
   output logic               instr_valid,
   output logic               done,
   output logic [CYCLE_W-1:0] cycle_count
);

   fetch_state_e       state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [CYCLE_W-1:0] cnt_q, cnt_d;
   logic [PC_W-1:0]    jmp_target;
   logic               halt;

   function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
      return (v == '1) ? v : v + CYCLE_W'(1);
   endfunction

   jump_lut #(.PC_W(PC_W)) u_lut (
`ifdef FETCH_LUT_WR_EN
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .wr_en_i   (lut_wr_en && (state_q == IDLE)),
      .wr_addr_i (lut_wr_addr),
      .wr_data_i (lut_wr_data),
`endif
      .rd_addr_i (LutPointer),
      .rd_data_o (jmp_target)
   );

   assign halt = is_halt(imem_data);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      instr       = NOP_INSTR;
      instr_valid = 1'b0;
      done        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               pc_d    = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            cnt_d = sat_inc(cnt_q);
            // HALT freezes the PC and outranks any jump request in the same cycle
            if (halt) begin
               state_d = DONE;
            end else begin
               instr       = imem_data;
               instr_valid = 1'b1;
               pc_d        = pc_jmp_en ? jmp_target : pc_q + PC_W'(1);
            end
         end
         DONE: begin
            done = 1'b1;
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign imem_addr   = pc_q;
   assign cycle_count = cnt_q;

endmodule
